// File: rtl/mips_regfile_32x32.sv
// 32x32 MIPS general-purpose register file with ALU status flags and a saturating write counter.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through on both read ports.
module mips_regfile_32x32 #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flag_we,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_cout,
  output logic [2:0]        flags,
  output logic [15:0]       wr_count
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [2:0]        flags_q;
  logic [2:0]        flags_d;
  logic [15:0]       wr_count_q;
  logic [15:0]       wr_count_d;
  logic              wr_commit;

  // A write to the zero register is dropped entirely and is not counted.
  assign wr_commit = we && (waddr != ZERO_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_commit) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (flag_we) begin
      flags_d = {alu_cout, alu_v, alu_z};
    end
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_commit && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= '0;
      wr_count_q <= '0;
    end else begin
      flags_q    <= flags_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    rdata_a = regs_q[raddr_a];
`ifdef REGFILE_BYPASS_EN
    // Bypass is suppressed while in reset so reads still return zero.
    if (rst_n && wr_commit && (raddr_a == waddr)) begin
      rdata_a = wdata;
    end
`else
`endif
    if (raddr_a == ZERO_IDX) begin
      rdata_a = '0;
    end
  end

  always_comb begin
    rdata_b = regs_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
    if (rst_n && wr_commit && (raddr_b == waddr)) begin
      rdata_b = wdata;
    end
`else
`endif
    if (raddr_b == ZERO_IDX) begin
      rdata_b = '0;
    end
  end

  assign flags    = flags_q;
  assign wr_count = wr_count_q;

endmodule

// File: doc/mips_regfile_32x32.md
Name: mips_regfile_32x32

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Sits directly upstream of the 32-bit ALU: read port A drives the ALU a operand; read port B drives the b operand (before the immediate mux).
- Also holds a 3-bit ALU status register that captures Z, V and cout on request, for later branch/overflow logic.
- One write port, fed from the write-back mux (ALU result r or memory data).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- ZERO_REG, 0, index of the hard-wired zero register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- raddr_a  input  ADDR_W  read port A index (rs).
- raddr_b  input  ADDR_W  read port B index (rt).
- rdata_a  output  DATA_W  register[raddr_a]; feeds ALU a.
- rdata_b  output  DATA_W  register[raddr_b]; feeds ALU b.
- we  input  1  write enable.
- waddr  input  ADDR_W  write index (rd/rt).
- wdata  input  DATA_W  write data.
- flag_we  input  1  capture ALU flags this cycle.
- alu_z  input  1  ALU zero flag.
- alu_v  input  1  ALU overflow flag.
- alu_cout  input  1  ALU carry-out.
- flags  output  3  registered {cout, V, Z}.
- wr_count  output  16  number of committed writes since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n low, asynchronous): all 32 registers, flags and wr_count clear to 0 immediately, with no clock edge needed. Reads during reset return 0.
- Reset released mid-operation: the first write commits on the first rising edge that sees rst_n high. A write pending at deassertion is not committed retroactively.
- Read:
  - Combinational, zero latency; rdata_x follows raddr_x within the same cycle.
  - Reading ZERO_REG always returns 0, regardless of any write.
- Write:
  - On the rising edge with we=1 and waddr != ZERO_REG, register[waddr] <= wdata. New data is visible on reads after that edge.
  - we=1 with waddr=ZERO_REG: no state change, and wr_count does not increment.
- wr_count:
  - Increments by 1 on each committed write (we=1, waddr != ZERO_REG).
  - Holds at 16'hFFFF once reached; does not wrap.
- Flags:
  - On the rising edge with flag_we=1, flags <= {alu_cout, alu_v, alu_z}; otherwise flags hold.
  - flag_we and we are independent. Both may be asserted in the same cycle, and both updates occur.
- Same-cycle read and write of the same index: see REGFILE_BYPASS_EN.
- Both read ports may address the same register simultaneously; both return the identical value.
- X/Z on waddr while we=0 must not corrupt any register.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass. If we=1, waddr != ZERO_REG and raddr_x == waddr, then rdata_x = wdata combinationally in the same cycle (both ports independently). The ZERO_REG read remains 0 even when bypassing.
- Not defined: reads always return the stored value. A same-cycle read of waddr returns the old contents until after the edge.

Test Plan:
- Reset: write 32'hDEADBEEF to r5, assert rst_n=0 asynchronously between edges -> rdata_a (raddr_a=5) drops to 0 before the next edge; flags=3'b000; wr_count=0.
- Basic write/read: write r1=32'h00000004, r2=32'h0000000A; raddr_a=1, raddr_b=2 -> rdata_a=32'h4, rdata_b=32'hA; wr_count=2.
- Zero register: we=1, waddr=0, wdata=32'hFFFFFFFF -> rdata_a (raddr_a=0)=0; wr_count unchanged.
- Same-cycle hazard: r3 holds 32'h11111111; write wdata=32'h22222222 to r3 with raddr_a=3 -> returns 32'h22222222 pre-edge with REGFILE_BYPASS_EN defined, 32'h11111111 without it; 32'h22222222 after the edge in both builds.
- Flags: alu_z=1, alu_v=0, alu_cout=1 with flag_we=1 -> flags=3'b101 after the edge. Next cycle: inputs 3'b010, flag_we=0 -> flags stay 3'b101.
- Saturation: force 65536 committed writes -> wr_count=16'hFFFF and holds on further writes.
